// File: rtl/memory_game_core.sv
// Memory-game controller for NxN grids (3..GRID_MAX): random pattern, timed show, player toggles, check and scoring.
// All outputs registered; en=0 freezes every register and masks the answer/wrong pulses, no other backpressure.
module memory_game_core #(
  parameter int          GRID_MAX      = 5,
  parameter int          SHOW_CYCLES   = 100000000,
  parameter int          RESULT_CYCLES = 50000000,
  parameter int          LIVES         = 3,
  parameter int          SCORE_W       = 12,
  parameter int          COMBO_W       = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic                                  start,
  input  logic [1:0]                            level,
  input  logic [$clog2(GRID_MAX*GRID_MAX)-1:0]  cell_sel,
  input  logic                                  cell_press,
  input  logic                                  submit,
  output logic [GRID_MAX*GRID_MAX-1:0]          pattern,
  output logic [GRID_MAX*GRID_MAX-1:0]          guess,
  output logic                                  show,
  output logic                                  answer,
  output logic                                  wrong,
  output logic [COMBO_W-1:0]                    o_combo,
  output logic [SCORE_W-1:0]                    o_score,
  output logic [2:0]                            o_life,
  output logic [2:0]                            o_state,
  output logic                                  game_over
);

  localparam int CELLS  = GRID_MAX * GRID_MAX;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int NN_W   = IDX_W + 1;
  localparam int NW     = $clog2(GRID_MAX + 1);
  localparam int TMAX   = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int TMR_W  = $clog2(TMAX) + 1;
  localparam int SUM_W  = ((SCORE_W > COMBO_W) ? SCORE_W : COMBO_W) + 8;
  localparam logic [TMR_W-1:0] SHOW_LAST   = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] RESULT_LAST = TMR_W'(RESULT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GEN    = 3'd1,
    SHOW   = 3'd2,
    INPUT  = 3'd3,
    CHECK  = 3'd4,
    RESULT = 3'd5,
    OVER   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   pattern_q, pattern_d;
  logic [CELLS-1:0]   guess_q, guess_d;
  logic               show_q, show_d;
  logic               answer_q, answer_d;
  logic               wrong_q, wrong_d;
  logic               over_q, over_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         life_q, life_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NW-1:0]      n_q, n_d;
  logic [NW-1:0]      cnt_q, cnt_d;
  logic [NN_W-1:0]    nn_q, nn_d;
  logic [15:0]        lfsr_q, lfsr_d;

  logic [IDX_W-1:0]   idx;
  logic [CELLS-1:0]   mask;
  logic [SUM_W-1:0]   sum;
  logic               enter_gen;
  int                 n_int;

  assign idx = lfsr_q[IDX_W-1:0];

  always_comb begin
    n_int = 3 + int'(level);
    if (n_int > GRID_MAX) n_int = GRID_MAX;
    for (int i = 0; i < CELLS; i++) mask[i] = (i < int'(nn_q));
    sum = SUM_W'(score_q) + SUM_W'(10 * (int'(n_q) - 2)) + SUM_W'(combo_q);
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    guess_d   = guess_q;
    show_d    = show_q;
    answer_d  = answer_q;
    wrong_d   = wrong_q;
    over_d    = over_q;
    combo_d   = combo_q;
    score_d   = score_q;
    life_d    = life_q;
    timer_d   = timer_q;
    n_d       = n_q;
    nn_d      = nn_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    enter_gen = 1'b0;
    if (en) begin
      answer_d = 1'b0;
      wrong_d  = 1'b0;
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            score_d   = '0;
            combo_d   = '0;
            life_d    = 3'(LIVES);
            over_d    = 1'b0;
            enter_gen = 1'b1;
          end
        end
        GEN: begin
          // Rejection sampling: out-of-grid or already-lit indices just wait for the next LFSR value
          if (({1'b0, idx} < nn_q) && !pattern_q[idx]) begin
            pattern_d[idx] = 1'b1;
            cnt_d          = cnt_q + NW'(1);
            if (cnt_q + NW'(1) == n_q) begin
              state_d = SHOW;
              show_d  = 1'b1;
              timer_d = '0;
            end
          end
        end
        SHOW: begin
          if (timer_q == SHOW_LAST) begin
            state_d = INPUT;
            show_d  = 1'b0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        INPUT: begin
          if (submit) begin
            state_d = CHECK;
          end else if (cell_press && ({1'b0, cell_sel} < nn_q)) begin
            guess_d[cell_sel] = ~guess_q[cell_sel];
          end
        end
        CHECK: begin
          timer_d = '0;
          state_d = RESULT;
          if (((pattern_q ^ guess_q) & mask) == '0) begin
            answer_d = 1'b1;
            score_d  = (sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
            if (combo_q != {COMBO_W{1'b1}}) combo_d = combo_q + COMBO_W'(1);
          end else begin
            wrong_d = 1'b1;
            combo_d = '0;
            life_d  = life_q - 3'd1;
            if (life_q == 3'd1) begin
              state_d = OVER;
              over_d  = 1'b1;
            end
          end
        end
        RESULT: begin
          if (timer_q == RESULT_LAST) enter_gen = 1'b1;
          else timer_d = timer_q + TMR_W'(1);
        end
        default: state_d = IDLE;
      endcase
      if (enter_gen) begin
        state_d   = GEN;
        n_d       = NW'(n_int);
        nn_d      = NN_W'(n_int * n_int);
        pattern_d = '0;
        guess_d   = '0;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      guess_q   <= '0;
      show_q    <= 1'b0;
      answer_q  <= 1'b0;
      wrong_q   <= 1'b0;
      over_q    <= 1'b0;
      combo_q   <= '0;
      score_q   <= '0;
      life_q    <= 3'(LIVES);
      timer_q   <= '0;
      n_q       <= NW'(3);
      nn_q      <= NN_W'(9);
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      guess_q   <= guess_d;
      show_q    <= show_d;
      answer_q  <= answer_d;
      wrong_q   <= wrong_d;
      over_q    <= over_d;
      combo_q   <= combo_d;
      score_q   <= score_d;
      life_q    <= life_d;
      timer_q   <= timer_d;
      n_q       <= n_d;
      nn_q      <= nn_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign pattern   = pattern_q;
  assign guess     = guess_q;
  assign show      = show_q;
  assign answer    = answer_q & en;
  assign wrong     = wrong_q & en;
  assign o_combo   = combo_q;
  assign o_score   = score_q;
  assign o_life    = life_q;
  assign o_state   = state_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core with short show/result windows.
module tb_memory_game_core;

  localparam int GRID_MAX = 5;
  localparam int CELLS    = GRID_MAX * GRID_MAX;
  localparam int IDX_W    = $clog2(CELLS);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       level = 2'd0;
  logic [IDX_W-1:0] cell_sel = '0;
  logic             cell_press = 1'b0;
  logic             submit = 1'b0;
  logic [CELLS-1:0] pattern, guess;
  logic             show, answer, wrong, game_over;
  logic [7:0]       o_combo;
  logic [11:0]      o_score;
  logic [2:0]       o_life, o_state;

  int nchk = 0;
  int nerr = 0;

  memory_game_core #(
    .GRID_MAX(GRID_MAX), .SHOW_CYCLES(4), .RESULT_CYCLES(2), .LIVES(3),
    .SCORE_W(12), .COMBO_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .level(level),
    .cell_sel(cell_sel), .cell_press(cell_press), .submit(submit),
    .pattern(pattern), .guess(guess), .show(show), .answer(answer), .wrong(wrong),
    .o_combo(o_combo), .o_score(o_score), .o_life(o_life), .o_state(o_state),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_show();
    for (int i = 0; i < 500 && !show; i++) tick();
    check("to_show", 32'(show), 32'd1);
  endtask

  task automatic wait_input(output int shows);
    shows = 0;
    for (int i = 0; i < 500 && o_state != 3'd3; i++) begin
      if (show) shows++;
      tick();
    end
    check("to_input", 32'(o_state), 32'd3);
  endtask

  task automatic copy_pattern();
    logic [CELLS-1:0] p;
    p = pattern;
    for (int i = 0; i < CELLS; i++) begin
      if (p[i]) begin
        cell_sel   = IDX_W'(i);
        cell_press = 1'b1;
        tick();
        cell_press = 1'b0;
      end
    end
  endtask

  // Submit from INPUT; returns with the CHECK outcome visible
  task automatic do_submit();
    submit = 1'b1;
    tick();
    submit = 1'b0;
    check("in_check", 32'(o_state), 32'd4);
    tick();
  endtask

  task automatic play_round(input bit do_copy, output int shows);
    wait_show();
    wait_input(shows);
    if (do_copy) copy_pattern();
    do_submit();
  endtask

  int shows;
  int n_frz;
  int exp_s, exp_c;
  bit sat_seen;
  logic [CELLS-1:0] pat_snap;

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_life", 32'(o_life), 32'd3);
    check("rst_score", 32'(o_score), 32'd0);
    check("rst_combo", 32'(o_combo), 32'd0);
    check("rst_pattern", 32'(pattern), 32'd0);
    check("rst_show", 32'(show), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);

    // Game 1, 3x3 grid
    level = 2'd0;
    start = 1'b1; tick(); start = 1'b0;
    check("gen_state", 32'(o_state), 32'd1);
    wait_show();
    check("pat_bits3", 32'($countones(pattern)), 32'd3);
    check("pat_in9", 32'(pattern & ~25'h1FF), 32'd0);
    wait_input(shows);
    check("show_len", 32'(shows), 32'd4);
    copy_pattern();
    check("guess_copy", 32'(guess), 32'(pattern));
    do_submit();
    check("ans1", 32'(answer), 32'd1);
    check("wrong1", 32'(wrong), 32'd0);
    check("score1", 32'(o_score), 32'd10);
    check("combo1", 32'(o_combo), 32'd1);
    tick();
    check("ans1_pulse", 32'(answer), 32'd0);

    play_round(1'b1, shows);
    check("ans2", 32'(answer), 32'd1);
    check("score2", 32'(o_score), 32'd21);
    check("combo2", 32'(o_combo), 32'd2);

    // 5x5 grid, three empty submissions end the game
    level = 2'd2;
    for (int r = 0; r < 3; r++) begin
      wait_show();
      if (r == 0) check("pat_bits5", 32'($countones(pattern)), 32'd5);
      wait_input(shows);
      do_submit();
      check("wrong_p", 32'(wrong), 32'd1);
      check("ans_p", 32'(answer), 32'd0);
      check("life_dec", 32'(o_life), 32'(2 - r));
      check("combo_clr", 32'(o_combo), 32'd0);
    end
    check("over_state", 32'(o_state), 32'd6);
    check("over_flag", 32'(game_over), 32'd1);
    tick(); tick(); tick();
    check("over_score", 32'(o_score), 32'd21);
    check("over_hold", 32'(o_state), 32'd6);

    // Game 2: restart from OVER
    level = 2'd0;
    start = 1'b1; tick(); start = 1'b0;
    check("re_life", 32'(o_life), 32'd3);
    check("re_score", 32'(o_score), 32'd0);
    check("re_state", 32'(o_state), 32'd1);
    check("re_over", 32'(game_over), 32'd0);
    wait_show();
    level = 2'd2;
    wait_input(shows);
    cell_sel = IDX_W'(9); cell_press = 1'b1; tick(); cell_press = 1'b0;
    check("sel_oob", 32'(guess), 32'd0);
    for (int i = 0; i < CELLS; i++) if (pattern[i]) cell_sel = IDX_W'(i);
    cell_press = 1'b1;
    do_submit();
    cell_press = 1'b0;
    check("press_drop", 32'(guess), 32'd0);
    check("drop_wrong", 32'(wrong), 32'd1);
    check("drop_life", 32'(o_life), 32'd2);

    // Freeze during SHOW (5x5 now latched)
    wait_show();
    pat_snap = pattern;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cell_sel   = IDX_W'(0);
      cell_press = i[0];
      tick();
    end
    cell_press = 1'b0;
    check("frz_show", 32'(show), 32'd1);
    check("frz_state", 32'(o_state), 32'd2);
    check("frz_pat", 32'(pattern), 32'(pat_snap));
    check("frz_guess", 32'(guess), 32'd0);
    en = 1'b1;
    n_frz = 0;
    while (o_state != 3'd3 && n_frz < 50) begin
      tick();
      n_frz++;
    end
    check("frz_timer", 32'(n_frz), 32'd4);
    check("pat_bits5b", 32'($countones(pattern)), 32'd5);
    copy_pattern();
    do_submit();
    check("ans5", 32'(answer), 32'd1);
    check("score5", 32'(o_score), 32'd30);
    check("combo5", 32'(o_combo), 32'd1);

    // Keep winning 5x5 rounds until the score saturates
    exp_s = 30;
    exp_c = 1;
    sat_seen = 1'b0;
    for (int r = 0; r < 80; r++) begin
      play_round(1'b1, shows);
      exp_s = exp_s + 30 + exp_c;
      if (exp_s > 4095) exp_s = 4095;
      exp_c++;
      check("run_score", 32'(o_score), 32'(exp_s));
      check("run_combo", 32'(o_combo), 32'(exp_c));
      if (sat_seen) break;
      if (exp_s == 4095) sat_seen = 1'b1;
    end
    check("score_sat", 32'(o_score), 32'd4095);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/memory_game_core.md
Name: memory_game_core

Overview:
- Parametrised successor to the fixed three-level memory-game controller.
- One FSM serves any square grid from 3x3 up to GRID_MAX x GRID_MAX, selected by level; replaces per-level FSMs plus output mux.
- Generates a pseudo-random lit pattern, shows it for a timed window, collects player cell toggles, checks on submit and keeps combo/score/life internally.
- Sits between the input debouncers and the display/seven-segment drivers.

Parameters:
- GRID_MAX, 5, largest grid side; CELLS = GRID_MAX*GRID_MAX.
- SHOW_CYCLES, 100000000, clk cycles the pattern stays visible.
- RESULT_CYCLES, 50000000, clk cycles the result is held before the next round.
- LIVES, 3, lives at game start (max 7).
- SCORE_W, 12, score width.
- COMBO_W, 8, combo width.
- LFSR_SEED, 16'hACE1, LFSR value after reset (nonzero).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  0 freezes all state, timers and LFSR
- start  in  1  1-cycle pulse; begins a new game from IDLE or OVER
- level  in  2  grid side = 3+level, clamped to GRID_MAX
- cell_sel  in  $clog2(CELLS)  row-major cell index r*N+c
- cell_press  in  1  1-cycle pulse; toggles guess[cell_sel]
- submit  in  1  1-cycle pulse; ends input phase
- pattern  out  CELLS  current target pattern, low N*N bits used
- guess  out  CELLS  player guess bits
- show  out  1  1 while pattern must be displayed
- answer  out  1  1-cycle pulse when submitted guess == pattern
- wrong  out  1  1-cycle pulse when guess != pattern
- o_combo  out  COMBO_W  consecutive correct rounds
- o_score  out  SCORE_W  score
- o_life  out  3  remaining lives
- o_state  out  3  FSM state code
- game_over  out  1  1 in OVER

Behaviour:
- All outputs registered. Reset: state IDLE (0), pattern 0, guess 0, show 0, answer 0, wrong 0, combo 0, score 0, life LIVES, game_over 0, LFSR LFSR_SEED, timers 0.
- States/codes: IDLE 0, GEN 1, SHOW 2, INPUT 3, CHECK 4, RESULT 5, OVER 6.
- en=0: no register changes, pulse outputs forced 0; inputs arriving while en=0 are dropped.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every enabled cycle in every state.
- IDLE/OVER + start: score, combo := 0, life := LIVES -> GEN. start in other states ignored.
- GEN entry: latch N = min(3+level, GRID_MAX); level changes afterwards ignored until next GEN. Clear pattern and guess. Each cycle take idx = lfsr[4:0] (width $clog2(CELLS)); if idx < N*N and pattern[idx]==0 set it, else reject. When N bits are set -> SHOW; show := 1, timer := 0.
- SHOW: timer counts; at SHOW_CYCLES-1 -> INPUT, show := 0. Inputs ignored.
- INPUT: cell_press with cell_sel < N*N toggles guess bit; cell_sel >= N*N ignored. submit -> CHECK. cell_press and submit together: submit wins, toggle dropped. Unbounded wait, no timeout.
- CHECK (one cycle): compare low N*N bits.
  - Equal: answer pulse; score += 10*(N-2) + combo (old value), saturating at 2^SCORE_W-1; combo += 1, saturating.
  - Unequal: wrong pulse; combo := 0; life -= 1.
  - Then -> RESULT (timer := 0), or -> OVER if life becomes 0.
- RESULT: pattern and guess stay visible; at RESULT_CYCLES-1 -> GEN.
- OVER: game_over=1; score and combo hold for display until start.
- reset mid-round: returns to reset values next edge regardless of state.

Test Plan:
- SHOW_CYCLES=4, RESULT_CYCLES=2. Reset -> o_state=0, o_life=3, o_score=0, pattern=0, LFSR=16'hACE1.
- level=0, start -> GEN sets exactly 3 bits within pattern[8:0]; show high exactly 4 cycles; INPUT entered.
- Copy pattern into guess via cell_press, submit -> answer pulse 1 cycle, o_score=10, o_combo=1; second correct round -> o_score=21, o_combo=2.
- level=2, submit empty guess three times -> wrong pulses, o_life 2,1,0, o_combo=0, OVER with game_over=1; score held; start -> life=3, score=0, GEN.
- level=0, cell_sel=9 press -> guess unchanged; same-cycle cell_press+submit -> toggle dropped, CHECK next cycle; level change during SHOW -> grid size unchanged.
- en=0 for 10 cycles during SHOW -> timer, LFSR and state frozen; show still high; press while frozen ignored. Preload score 4090, level=2 correct -> score saturates 4095.
